// File: rtl/rv32i_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rv32i_pkg
//  Description : Shared widths, index types and select helpers for the RV32I
//                register file and program-counter logic.
//  Revision    : 1.0 - initial release
// ============================================================================
package rv32i_pkg;

  localparam int XLEN      = 32;
  localparam int NREG      = 32;
  localparam int REG_IDX_W = 5;

  localparam logic [REG_IDX_W-1:0] REG_ZERO = 5'd0;

  // Default reset vector; the low two bits must stay clear.
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef logic [REG_IDX_W-1:0] reg_idx_t;
  typedef logic [XLEN-1:0]      xword_t;

  // Register index carried in the low bits of a 32-bit select bus.
  function automatic reg_idx_t sel_idx(input logic [31:0] sel);
    return sel[REG_IDX_W-1:0];
  endfunction

  // True when a select bus carries anything above the index field.
  function automatic logic sel_upper_nonzero(input logic [31:0] sel);
    return |sel[31:REG_IDX_W];
  endfunction

endpackage : rv32i_pkg
`default_nettype wire

// File: rtl/rv32i_pc_reg.sv
`default_nettype none
// ============================================================================
//  Module      : rv32i_pc_reg
//  Description : Program-counter register with load strobe, word-alignment
//                masking and a sticky misaligned-load flag. The PC never
//                advances on its own; the caller supplies every next value.
//  Revision    : 1.0 - initial release
// ============================================================================
module rv32i_pc_reg #(
  parameter int               XLEN     = rv32i_pkg::XLEN,
  parameter logic [XLEN-1:0]  RESET_PC = XLEN'(rv32i_pkg::RESET_PC_DEFAULT)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            pc_load,
  input  logic [XLEN-1:0] pc_in,
  output logic [XLEN-1:0] pc_out,
  output logic            pc_misalign
);

  import rv32i_pkg::*;

  // Clears the byte-offset bits so the PC is always word aligned.
  localparam logic [XLEN-1:0] PC_ALIGN_MASK = {{(XLEN-2){1'b1}}, 2'b00};

  logic [XLEN-1:0] pc_d;
  logic [XLEN-1:0] pc_q;
  logic            misalign_d;
  logic            misalign_q;

  // Next-state: load the aligned PC on strobe, flag any dropped offset bits.
  always_comb begin
    pc_d       = pc_q;
    misalign_d = misalign_q;
    if (pc_load) begin
      pc_d = pc_in & PC_ALIGN_MASK;
      if (pc_in[1:0] != 2'b00) begin
        misalign_d = 1'b1;
      end
    end
  end

  // State flops; reset vector is masked as well so the PC can never be odd.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= RESET_PC & PC_ALIGN_MASK;
      misalign_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      misalign_q <= misalign_d;
    end
  end

  assign pc_out      = pc_q;
  assign pc_misalign = misalign_q;

endmodule : rv32i_pc_reg
`default_nettype wire

// File: rtl/rv32i_regfile.sv
`default_nettype none
// ============================================================================
//  Module      : rv32i_regfile
//  Description : RV32I integer register file (x1..x31 stored, x0 hardwired
//                to zero) with one write port, two combinational read ports,
//                optional write-through bypass, sticky select-error flag and
//                the program counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module rv32i_regfile #(
  parameter int               XLEN     = rv32i_pkg::XLEN,
  parameter logic [XLEN-1:0]  RESET_PC = XLEN'(rv32i_pkg::RESET_PC_DEFAULT),
  parameter bit               BYPASS   = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [31:0]     reg_sel_rs1,
  input  logic [31:0]     reg_sel_rs2,
  input  logic [31:0]     reg_sel_rd,
  input  logic [XLEN-1:0] reg_rd,
  input  logic [XLEN-1:0] pc_in,
  input  logic [31:0]     pc_in_vld,
  output logic [XLEN-1:0] reg_rs1,
  output logic [XLEN-1:0] reg_rs2,
  output logic [XLEN-1:0] pc_out,
  output logic            sel_err,
  output logic            pc_misalign
);

  import rv32i_pkg::*;

  // --------------------------------------------------------------------------
  // Select decode
  // --------------------------------------------------------------------------
  reg_idx_t w_rs1_idx;
  reg_idx_t w_rs2_idx;
  reg_idx_t w_rd_idx;
  logic     w_sel_upper;

  assign w_rs1_idx   = sel_idx(reg_sel_rs1);
  assign w_rs2_idx   = sel_idx(reg_sel_rs2);
  assign w_rd_idx    = sel_idx(reg_sel_rd);
  assign w_sel_upper = sel_upper_nonzero(reg_sel_rs1)
                     | sel_upper_nonzero(reg_sel_rs2)
                     | sel_upper_nonzero(reg_sel_rd);

  // Only bit 0 of the PC strobe carries meaning.
  logic unused_pc_vld_hi;
  assign unused_pc_vld_hi = ^pc_in_vld[31:1];

  // --------------------------------------------------------------------------
  // Register array: x0 is not stored, so the array starts at index 1.
  // --------------------------------------------------------------------------
  logic [XLEN-1:0] regs_d [1:NREG-1];
  logic [XLEN-1:0] regs_q [1:NREG-1];

  // Next-state: every edge writes rd; rd = x0 matches no stored entry.
  always_comb begin
    for (int i = 1; i < NREG; i++) begin
      regs_d[i] = (w_rd_idx == reg_idx_t'(i)) ? reg_rd : regs_q[i];
    end
  end

  for (genvar gi = 1; gi < NREG; gi++) begin : g_xreg
    // One flop word per architectural register; cleared on reset.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        regs_q[gi] <= '0;
      end else begin
        regs_q[gi] <= regs_d[gi];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Read muxes (array contents only; x0 falls through as zero)
  // --------------------------------------------------------------------------
  logic [XLEN-1:0] w_rs1_arr;
  logic [XLEN-1:0] w_rs2_arr;

  // Select array contents for both read ports; unmatched index 0 yields zero.
  always_comb begin
    w_rs1_arr = '0;
    w_rs2_arr = '0;
    for (int i = 1; i < NREG; i++) begin
      if (w_rs1_idx == reg_idx_t'(i)) begin
        w_rs1_arr = regs_q[i];
      end
      if (w_rs2_idx == reg_idx_t'(i)) begin
        w_rs2_arr = regs_q[i];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Write-through bypass: a read of the register being written this cycle
  // returns the incoming data. Never applies to x0.
  // --------------------------------------------------------------------------
  logic w_byp_rs1;
  logic w_byp_rs2;

  if (BYPASS) begin : g_bypass
    assign w_byp_rs1 = (w_rs1_idx == w_rd_idx) && (w_rd_idx != REG_ZERO);
    assign w_byp_rs2 = (w_rs2_idx == w_rd_idx) && (w_rd_idx != REG_ZERO);
  end else begin : g_no_bypass
    assign w_byp_rs1 = 1'b0;
    assign w_byp_rs2 = 1'b0;
  end

  assign reg_rs1 = w_byp_rs1 ? reg_rd : w_rs1_arr;
  assign reg_rs2 = w_byp_rs2 ? reg_rd : w_rs2_arr;

  // --------------------------------------------------------------------------
  // Sticky select error
  // --------------------------------------------------------------------------
  logic sel_err_d;
  logic sel_err_q;

  // Once any select shows stray upper bits the flag stays up until reset.
  always_comb begin
    sel_err_d = sel_err_q | w_sel_upper;
  end

  // Sticky flag flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_err_q <= 1'b0;
    end else begin
      sel_err_q <= sel_err_d;
    end
  end

  assign sel_err = sel_err_q;

  // --------------------------------------------------------------------------
  // Program counter
  // --------------------------------------------------------------------------
  rv32i_pc_reg #(
    .XLEN     (XLEN),
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk         (clk),
    .rst_n       (rst_n),
    .pc_load     (pc_in_vld[0]),
    .pc_in       (pc_in),
    .pc_out      (pc_out),
    .pc_misalign (pc_misalign)
  );

endmodule : rv32i_regfile
`default_nettype wire

// File: tb/tb_rv32i_regfile.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rv32i_regfile
//  Description : Self-checking bench for rv32i_regfile. Two instances (with and
//                without bypass) share one stimulus stream and are compared
//                every cycle against a behavioural model of the register file.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rv32i_regfile;

  localparam logic [31:0] C_RESET_PC = 32'h0000_0200;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] reg_sel_rs1 = '0;
  logic [31:0] reg_sel_rs2 = '0;
  logic [31:0] reg_sel_rd  = '0;
  logic [31:0] reg_rd      = '0;
  logic [31:0] pc_in       = '0;
  logic [31:0] pc_in_vld   = '0;

  logic [31:0] byp_rs1, byp_rs2, byp_pc;
  logic        byp_sel_err, byp_mis;
  logic [31:0] nb_rs1, nb_rs2, nb_pc;
  logic        nb_sel_err, nb_mis;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  rv32i_regfile #(.XLEN(32), .RESET_PC(C_RESET_PC), .BYPASS(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .reg_sel_rs1(reg_sel_rs1), .reg_sel_rs2(reg_sel_rs2), .reg_sel_rd(reg_sel_rd),
    .reg_rd(reg_rd), .pc_in(pc_in), .pc_in_vld(pc_in_vld),
    .reg_rs1(byp_rs1), .reg_rs2(byp_rs2), .pc_out(byp_pc),
    .sel_err(byp_sel_err), .pc_misalign(byp_mis)
  );

  rv32i_regfile #(.XLEN(32), .RESET_PC(C_RESET_PC), .BYPASS(1'b0)) dut_nb (
    .clk(clk), .rst_n(rst_n),
    .reg_sel_rs1(reg_sel_rs1), .reg_sel_rs2(reg_sel_rs2), .reg_sel_rd(reg_sel_rd),
    .reg_rd(reg_rd), .pc_in(pc_in), .pc_in_vld(pc_in_vld),
    .reg_rs1(nb_rs1), .reg_rs2(nb_rs2), .pc_out(nb_pc),
    .sel_err(nb_sel_err), .pc_misalign(nb_mis)
  );

  // ---------------------------------------------------------------------------
  // Behavioural model: architectural state as a plain array plus flags.
  // ---------------------------------------------------------------------------
  logic [31:0] m_regs [32];
  logic [31:0] m_pc;
  logic        m_sel_err;
  logic        m_mis;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) m_regs[i] <= 32'h0;
      m_pc      <= C_RESET_PC;
      m_sel_err <= 1'b0;
      m_mis     <= 1'b0;
    end else begin
      if (reg_sel_rd[4:0] != 5'd0) m_regs[reg_sel_rd[4:0]] <= reg_rd;
      if ((reg_sel_rs1[31:5] != 0) || (reg_sel_rs2[31:5] != 0) || (reg_sel_rd[31:5] != 0))
        m_sel_err <= 1'b1;
      if (pc_in_vld[0]) begin
        m_pc <= {pc_in[31:2], 2'b00};
        if (pc_in[1:0] != 2'b00) m_mis <= 1'b1;
      end
    end
  end

  // Value a read port must show right now under the given bypass setting.
  function automatic logic [31:0] exp_read(input logic [31:0] sel, input bit byp);
    int idx;
    int wr;
    idx = int'(sel[4:0]);
    wr  = int'(reg_sel_rd[4:0]);
    if (idx == 0) return 32'h0;
    if (byp && (idx == wr)) return reg_rd;
    return m_regs[idx];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    chk("cyc_byp_rs1", byp_rs1, exp_read(reg_sel_rs1, 1'b1));
    chk("cyc_byp_rs2", byp_rs2, exp_read(reg_sel_rs2, 1'b1));
    chk("cyc_nb_rs1",  nb_rs1,  exp_read(reg_sel_rs1, 1'b0));
    chk("cyc_nb_rs2",  nb_rs2,  exp_read(reg_sel_rs2, 1'b0));
    chk("cyc_byp_pc",  byp_pc,  m_pc);
    chk("cyc_nb_pc",   nb_pc,   m_pc);
    chk("cyc_byp_serr", {31'h0, byp_sel_err}, {31'h0, m_sel_err});
    chk("cyc_nb_serr",  {31'h0, nb_sel_err},  {31'h0, m_sel_err});
    chk("cyc_byp_mis",  {31'h0, byp_mis},     {31'h0, m_mis});
    chk("cyc_nb_mis",   {31'h0, nb_mis},      {31'h0, m_mis});
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    reg_sel_rs1 = '0; reg_sel_rs2 = '0; reg_sel_rd = '0;
    reg_rd = '0; pc_in = '0; pc_in_vld = '0;
  endtask

  task automatic random_cycle();
    logic [31:0] r;
    reg_sel_rd  = {27'h0, 5'($urandom_range(0, 31))};
    reg_rd      = $urandom;
    r = $urandom;
    reg_sel_rs1 = (r[1:0] == 2'b00) ? reg_sel_rd : {27'h0, 5'($urandom_range(0, 31))};
    reg_sel_rs2 = (r[3:2] == 2'b00) ? reg_sel_rd : {27'h0, 5'($urandom_range(0, 31))};
    if ($urandom_range(0, 99) == 0) reg_sel_rs1[31:5] = 27'($urandom);
    if ($urandom_range(0, 99) == 0) reg_sel_rs2[31:5] = 27'($urandom);
    if ($urandom_range(0, 99) == 0) reg_sel_rd[31:5]  = 27'($urandom);
    pc_in = $urandom;
    if ($urandom_range(0, 7) != 0) pc_in[1:0] = 2'b00;
    pc_in_vld = $urandom;
    pc_in_vld[0] = ($urandom_range(0, 3) == 0);
  endtask

  initial begin
    // ---------------- reset ----------------
    idle_inputs();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 32; i++) begin
      reg_sel_rs1 = i;
      reg_sel_rs2 = 31 - i;
      #1;
      chk("rst_rs1_byp", byp_rs1, 32'h0);
      chk("rst_rs2_nb",  nb_rs2,  32'h0);
    end
    chk("rst_pc",      byp_pc, C_RESET_PC);
    chk("rst_pc_nb",   nb_pc,  C_RESET_PC);
    chk("rst_sel_err", {31'h0, byp_sel_err}, 32'h0);
    chk("rst_mis",     {31'h0, nb_mis},      32'h0);

    // ---------------- write / read-back ----------------
    step(); reg_sel_rd = 5; reg_rd = 32'hDEAD_BEEF; reg_sel_rs1 = 0; reg_sel_rs2 = 0;
    step(); reg_sel_rd = 0; reg_rd = 32'h1234_5678;
    step(); reg_sel_rs1 = 5; reg_sel_rs2 = 0;
    #1;
    chk("wr_x5_byp", byp_rs1, 32'hDEAD_BEEF);
    chk("wr_x5_nb",  nb_rs1,  32'hDEAD_BEEF);
    chk("wr_x0_byp", byp_rs2, 32'h0);
    chk("model_x5",  m_regs[5], 32'hDEAD_BEEF);
    chk("model_x0",  m_regs[0], 32'h0);

    // ---------------- bypass ----------------
    reg_sel_rd = 7; reg_rd = 32'h11;
    step(); reg_rd = 32'hA5A5_0001; reg_sel_rs1 = 7; reg_sel_rs2 = 7;
    #1;
    chk("byp_rs1_on",  byp_rs1, 32'hA5A5_0001);
    chk("byp_rs2_on",  byp_rs2, 32'hA5A5_0001);
    chk("byp_rs1_off", nb_rs1,  32'h11);
    chk("byp_rs2_off", nb_rs2,  32'h11);
    step(); reg_sel_rd = 0;
    #1;
    chk("byp_next_on",  byp_rs1, 32'hA5A5_0001);
    chk("byp_next_off", nb_rs2,  32'hA5A5_0001);

    // ---------------- PC load ----------------
    pc_in = 32'h0000_1003; pc_in_vld = 32'h1;
    step(); pc_in_vld = 32'hFFFF_FFFE; pc_in = 32'h0000_7777;
    chk("pc_load",     byp_pc, 32'h0000_1000);
    chk("pc_mis_set",  {31'h0, byp_mis}, 32'h1);
    for (int k = 0; k < 4; k++) begin
      step();
      chk("pc_hold",    nb_pc, 32'h0000_1000);
      chk("pc_mis_hold", {31'h0, nb_mis}, 32'h1);
    end
    pc_in_vld = 0;

    // ---------------- select error ----------------
    reg_sel_rd = 3; reg_rd = 32'h33;
    step(); reg_sel_rd = 0; reg_sel_rs2 = 32'h0000_0023;
    #1;
    chk("serr_read",   byp_rs2, 32'h33);
    chk("serr_before", {31'h0, byp_sel_err}, 32'h0);
    step(); reg_sel_rs2 = 3;
    chk("serr_set", {31'h0, byp_sel_err}, 32'h1);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("serr_sticky", {31'h0, nb_sel_err}, 32'h1);
    end

    // ---------------- reset mid-operation ----------------
    reg_sel_rd = 9; reg_rd = 32'hFF; reg_sel_rs1 = 9; reg_sel_rs2 = 0;
    pc_in = 32'h0000_4000; pc_in_vld = 32'h1;
    step(); step();
    chk("pre_rst_x9", nb_rs1, 32'hFF);
    chk("pre_rst_pc", byp_pc, 32'h0000_4000);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("async_rst_x9",   nb_rs1, 32'h0);
    chk("async_rst_pc",   byp_pc, C_RESET_PC);
    chk("async_rst_serr", {31'h0, byp_sel_err}, 32'h0);
    chk("async_rst_mis",  {31'h0, byp_mis},     32'h0);
    idle_inputs();
    step(); step();
    rst_n = 1'b1;

    // ---------------- randomized bursts, reset between ----------------
    for (int b = 0; b < 4; b++) begin
      for (int c = 0; c < 500; c++) begin
        step();
        random_cycle();
      end
      step();
      idle_inputs();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
    end

    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_rv32i_regfile
`default_nettype wire

// File: doc/rv32i_regfile.md
Name: rv32i_regfile

Overview:
- Responder side of the core's register-file/PC channel: holds the 31 writable RV32I integer registers (x1..x31), a hardwired-zero x0, and the program counter.
- Sits below the decode/execute logic. The execute side drives the selects, write data and PC update; this block returns the rs1/rs2 operands and the current PC.
- One write port, two read ports and one PC register, with optional write-through bypass on reads.

Parameters:
- XLEN, 32, data and PC width.
- RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0.
- BYPASS, 1, 1 = a read of the register being written this cycle returns reg_rd; 0 = it returns the old contents.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- reg_sel_rs1  in  32  rs1 index; bits [4:0] used.
- reg_sel_rs2  in  32  rs2 index; bits [4:0] used.
- reg_sel_rd  in  32  rd index; bits [4:0] used; 0 = no write.
- reg_rd  in  32  write data for rd.
- pc_in  in  32  next PC value.
- pc_in_vld  in  32  PC load strobe; bit 0 used.
- reg_rs1  out  32  rs1 read data.
- reg_rs2  out  32  rs2 read data.
- pc_out  out  32  current PC (registered).
- sel_err  out  1  sticky: some select arrived with nonzero bits [31:5].
- pc_misalign  out  1  sticky: a PC load arrived with pc_in[1:0] != 0.

Behaviour:
- Reset (rst_n low, asynchronous assert, synchronous release on the clk edge):
  - x1..x31 = 0; pc_out = RESET_PC; sel_err = 0; pc_misalign = 0.
  - Reset asserted mid-cycle clears state immediately. A write sampled on the edge where rst_n is low is lost.
- Write:
  - There is no separate write enable. On every rising edge, regs[reg_sel_rd[4:0]] <= reg_rd when reg_sel_rd[4:0] != 0.
  - Index 0 discards the write. The execute side suppresses a write by selecting x0.
- Read:
  - Combinational, zero-cycle latency. reg_rs1 = 0 when reg_sel_rs1[4:0] == 0, else the array contents; same rule for rs2.
  - BYPASS=1: when the read index equals the write index and is nonzero, the output is reg_rd in the same cycle.
  - rs1 == rs2 == rd with the same nonzero index: both outputs are bypassed identically.
  - Bypass is never applied to index 0.
- Upper select bits [31:5]:
  - Ignored for addressing.
  - Any nonzero upper bit on any of the three selects sets sel_err at the next edge.
  - sel_err holds until reset.
- PC (edge-triggered):
  - pc_in_vld[0] = 1: pc_out <= {pc_in[31:2], 2'b00}. If pc_in[1:0] != 0, pc_misalign is also set and holds until reset.
  - pc_in_vld[0] = 0: pc_out holds.
  - pc_in_vld[31:1] are ignored.
  - The block never increments the PC on its own; next-PC arithmetic belongs to the execute side.
- Simultaneous events: a register write and a PC load in the same cycle are independent and both take effect.
- Width rules: no arithmetic other than masking; all datapaths are XLEN wide.
- Implementation targets: a flop array for x1..x31, x0 not stored, reads as muxes.

Decomposition:
- Package rv32i_pkg:
  - XLEN, NREG = 32, REG_IDX_W = 5, REG_ZERO = 5'd0.
  - typedef reg_idx_t (logic [4:0]).
  - typedef xword_t (logic [XLEN-1:0]).
  - Default RESET_PC constant.
- Sub-module rv32i_pc_reg:
  - Contains the PC flop, load strobe, alignment masking and the pc_misalign sticky.
  - Reused by later fetch logic.
- The register array and bypass stay in rv32i_regfile.

Test Plan:
- Reset check: hold rst_n low 3 cycles, then release. Required: pc_out = RESET_PC, rs1/rs2 = 0 for all 32 indices, both stickies 0.
- Write/read-back: write x5 = 32'hDEAD_BEEF, then write x0 = 32'h1234_5678. Next cycle with sel_rs1 = 5 and sel_rs2 = 0: reg_rs1 = 32'hDEAD_BEEF, reg_rs2 = 0.
- Bypass: same cycle, sel_rd = 7, reg_rd = 32'hA5A5_0001, sel_rs1 = sel_rs2 = 7, x7 previously 32'h11.
  - BYPASS=1: both outputs = 32'hA5A5_0001 combinationally.
  - BYPASS=0: both outputs = 32'h11.
  - Next cycle: 32'hA5A5_0001 regardless of BYPASS.
- PC load: pc_in = 32'h0000_1003 with pc_in_vld = 1. Next edge: pc_out = 32'h0000_1000, pc_misalign = 1. Then pc_in_vld = 0 for 4 cycles: pc_out unchanged, pc_misalign stays 1.
- Select error: sel_rs2 = 32'h0000_0023 with x3 = 32'h33. Required: reg_rs2 = 32'h33, sel_err = 1 after the edge and sticky.
- Reset mid-operation: write x9 = 32'hFF each cycle and load the PC, then assert rst_n asynchronously between edges. Required: x9 = 0 and pc_out = RESET_PC immediately, before the next edge.
